// File: rtl/aste_pkg.sv
// +--------------------------------------------------------------------+
// | aste_pkg: asteroid memory field layout and frame-reader states     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package aste_pkg;

  localparam int POS_X_MSB     = 9;
  localparam int POS_X_LSB     = 6;
  localparam int POS_Y_MSB     = 5;
  localparam int POS_Y_LSB     = 2;
  localparam int OPCODE_MSB    = 1;

  localparam int BIT_LOADED    = 1;
  localparam int BIT_DESTRUIDO = 0;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LIMPA   = 3'd1,
    LEITURA = 3'd2,
    ENVIA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/quadro_bitmap.sv
// +--------------------------------------------------------------------+
// | quadro_bitmap: square occupancy flop array, clear/set/row-read     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module quadro_bitmap #(
  parameter int LARG_COOR = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    limpa,
  input  logic                    nave_en,
  input  logic [LARG_COOR-1:0]    nave_x,
  input  logic [LARG_COOR-1:0]    nave_y,
  input  logic                    set_en,
  input  logic [LARG_COOR-1:0]    set_x,
  input  logic [LARG_COOR-1:0]    set_y,
  output logic                    cel_valor,
  input  logic [LARG_COOR-1:0]    linha_sel,
  output logic [2**LARG_COOR-1:0] linha_out
);

  localparam int LADO = 2**LARG_COOR;

  logic [LADO-1:0] mapa [LADO];

  // Clear and ship-set share the LIMPA cycle; the later assignment wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LADO; i++) mapa[i] <= '0;
    end else if (limpa) begin
      for (int i = 0; i < LADO; i++) mapa[i] <= '0;
      if (nave_en) mapa[nave_y][nave_x] <= 1'b1;
    end else if (set_en) begin
      mapa[set_y][set_x] <= 1'b1;
    end
  end

  assign cel_valor = mapa[set_y][set_x];
  assign linha_out = mapa[linha_sel];

endmodule

`default_nettype wire

// File: rtl/leitor_quadro_aste.sv
// +--------------------------------------------------------------------+
// | leitor_quadro_aste: rasterises live asteroids + ship, streams rows |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module leitor_quadro_aste
  import aste_pkg::*;
#(
  parameter int N_ASTE    = 16,
  parameter int LARG_END  = 4,
  parameter int LARG_COOR = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    iniciar,
  output logic [LARG_END-1:0]     mem_addr,
  input  logic [9:0]              mem_dado,
  input  logic [1:0]              mem_load,
  input  logic                    mostra_nave,
  input  logic [LARG_COOR-1:0]    nave_coor_x,
  input  logic [LARG_COOR-1:0]    nave_coor_y,
  output logic                    linha_valida,
  input  logic                    linha_pronta,
  output logic [LARG_COOR-1:0]    linha_idx,
  output logic [2**LARG_COOR-1:0] linha_dados,
  output logic                    ocupado,
  output logic                    fim_quadro,
  output logic [LARG_END:0]       contagem_aste,
  output logic                    sobreposicao
);

  localparam int LADO = 2**LARG_COOR;

  estado_t               estado, prox_estado;
  logic [LARG_END-1:0]   k;
  logic [LARG_COOR-1:0]  pos_x, pos_y;
  logic                  vivo, cel_ocupada, ultimo_k, ultima_linha;
  logic [LADO-1:0]       linha_bitmap;
  logic                  opcode_unused;

  assign pos_x         = mem_dado[POS_X_MSB:POS_X_LSB];
  assign pos_y         = mem_dado[POS_Y_MSB:POS_Y_LSB];
  assign opcode_unused = ^mem_dado[OPCODE_MSB:0];
  assign vivo          = (estado == LEITURA) && mem_load[BIT_LOADED] && !mem_load[BIT_DESTRUIDO];
  assign ultimo_k      = (k == LARG_END'(N_ASTE - 1));
  assign ultima_linha  = (linha_idx == {LARG_COOR{1'b1}});

  quadro_bitmap #(
    .LARG_COOR (LARG_COOR)
  ) u_bitmap (
    .clock     (clock),
    .reset_n   (reset_n),
    .limpa     (estado == LIMPA),
    .nave_en   (mostra_nave),
    .nave_x    (nave_coor_x),
    .nave_y    (nave_coor_y),
    .set_en    (vivo),
    .set_x     (pos_x),
    .set_y     (pos_y),
    .cel_valor (cel_ocupada),
    .linha_sel (linha_idx),
    .linha_out (linha_bitmap)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox_estado;
  end

  // Memory has one cycle of read latency, so the address runs one slot ahead of k.
  always_comb begin
    prox_estado  = estado;
    mem_addr     = '0;
    linha_valida = 1'b0;
    fim_quadro   = 1'b0;
    ocupado      = (estado != OCIOSO);
    linha_dados  = '0;
    case (estado)
      OCIOSO:  if (iniciar) prox_estado = LIMPA;
      LIMPA:   prox_estado = LEITURA;
      LEITURA: begin
        mem_addr = k + LARG_END'(1);
        if (ultimo_k) prox_estado = ENVIA;
      end
      ENVIA: begin
        linha_valida = 1'b1;
        linha_dados  = linha_bitmap;
        if (linha_pronta && ultima_linha) prox_estado = FIM;
      end
      FIM: begin
        fim_quadro  = 1'b1;
        prox_estado = OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k             <= '0;
      linha_idx     <= '0;
      contagem_aste <= '0;
      sobreposicao  <= 1'b0;
    end else begin
      case (estado)
        LIMPA: begin
          k             <= '0;
          contagem_aste <= '0;
          sobreposicao  <= 1'b0;
        end
        LEITURA: begin
          k <= k + LARG_END'(1);
          if (ultimo_k) linha_idx <= '0;
          if (vivo) begin
            contagem_aste <= contagem_aste + (LARG_END+1)'(1);
            if (cel_ocupada) sobreposicao <= 1'b1;
          end
        end
        ENVIA: begin
          if (linha_pronta && !ultima_linha) linha_idx <= linha_idx + LARG_COOR'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_leitor_quadro_aste.sv
// +--------------------------------------------------------------------+
// | tb_leitor_quadro_aste: directed frames against hand-computed rows  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_leitor_quadro_aste;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        iniciar;
  logic [3:0]  mem_addr;
  logic [9:0]  mem_dado;
  logic [1:0]  mem_load;
  logic        mostra_nave;
  logic [3:0]  nave_coor_x, nave_coor_y;
  logic        linha_valida, linha_pronta;
  logic [3:0]  linha_idx;
  logic [15:0] linha_dados;
  logic        ocupado, fim_quadro;
  logic [4:0]  contagem_aste;
  logic        sobreposicao;

  int checks = 0;
  int errors = 0;

  logic [9:0]  pos_mem  [16];
  logic [1:0]  load_mem [16];
  logic [15:0] rows_cap [16];
  logic [15:0] exp_rows [16];

  always #5 clock = ~clock;

  leitor_quadro_aste dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .iniciar       (iniciar),
    .mem_addr      (mem_addr),
    .mem_dado      (mem_dado),
    .mem_load      (mem_load),
    .mostra_nave   (mostra_nave),
    .nave_coor_x   (nave_coor_x),
    .nave_coor_y   (nave_coor_y),
    .linha_valida  (linha_valida),
    .linha_pronta  (linha_pronta),
    .linha_idx     (linha_idx),
    .linha_dados   (linha_dados),
    .ocupado       (ocupado),
    .fim_quadro    (fim_quadro),
    .contagem_aste (contagem_aste),
    .sobreposicao  (sobreposicao)
  );

  // Synchronous-read memory model: data appears one cycle after the address.
  always @(posedge clock) begin
    mem_dado <= pos_mem[mem_addr];
    mem_load <= load_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 16; i++) begin
      pos_mem[i]  = 10'h0;
      load_mem[i] = 2'b00;
      exp_rows[i] = 16'h0;
    end
  endtask

  // Opcode bits set to 2'b11 on purpose; they must not matter.
  task automatic set_entry(input int idx, input int x, input int y, input logic [1:0] ld);
    pos_mem[idx]  = {x[3:0], y[3:0], 2'b11};
    load_mem[idx] = ld;
  endtask

  task automatic run_frame(input int stall_row, input int stall_len, input bit poke, output int fim_cyc);
    int cyc, nxt, stalls;
    logic [15:0] held;
    nxt = 0; stalls = 0; fim_cyc = -1; held = '0;
    for (int i = 0; i < 16; i++) rows_cap[i] = 16'hdead;
    @(negedge clock); iniciar = 1'b1; linha_pronta = 1'b1;
    @(negedge clock); iniciar = 1'b0; cyc = 1;
    check("ocupado_limpa", {31'b0, ocupado}, 1);
    check("addr_limpa", {28'b0, mem_addr}, 0);
    while (cyc < 200) begin
      if (fim_quadro) begin
        fim_cyc = cyc;
        break;
      end
      if (cyc >= 2 && cyc <= 17)
        check($sformatf("addr_k%0d", cyc - 2), {28'b0, mem_addr}, (cyc - 1) % 16);
      iniciar = 1'b0;
      linha_pronta = 1'b1;
      if (linha_valida) begin
        if (int'(linha_idx) == stall_row && stalls < stall_len) begin
          if (stalls == 0) held = linha_dados;
          else check("stall_dados", {16'b0, linha_dados}, {16'b0, held});
          check("stall_idx", {28'b0, linha_idx}, stall_row);
          linha_pronta = 1'b0;
          iniciar = poke;
          stalls++;
        end else begin
          check("linha_idx", {28'b0, linha_idx}, nxt);
          rows_cap[linha_idx] = linha_dados;
          nxt++;
        end
      end
      @(negedge clock); cyc++;
    end
    if (fim_cyc < 0) check("fim_timeout", 0, 1);
    check("linhas_aceitas", nxt, 16);
    iniciar = 1'b0;
    linha_pronta = 1'b1;
  endtask

  task automatic verifica(input string nome, input int fim_cyc, input int fim_exp,
                          input int cnt, input bit sob);
    check({nome, "_fim_ciclo"}, fim_cyc, fim_exp);
    check({nome, "_valida_fim"}, {31'b0, linha_valida}, 0);
    check({nome, "_contagem"}, {27'b0, contagem_aste}, cnt);
    check({nome, "_sobrepos"}, {31'b0, sobreposicao}, {31'b0, sob});
    for (int r = 0; r < 16; r++)
      check($sformatf("%s_row%0d", nome, r), {16'b0, rows_cap[r]}, {16'b0, exp_rows[r]});
    @(negedge clock);
    check({nome, "_ocioso"}, {31'b0, ocupado}, 0);
    check({nome, "_fim_pulso"}, {31'b0, fim_quadro}, 0);
    check({nome, "_contagem_mantida"}, {27'b0, contagem_aste}, cnt);
    check({nome, "_sob_mantida"}, {31'b0, sobreposicao}, {31'b0, sob});
  endtask

  initial begin
    int fc;
    reset_n = 1'b0; iniciar = 1'b0; linha_pronta = 1'b1;
    mostra_nave = 1'b0; nave_coor_x = '0; nave_coor_y = '0;
    clear_all();
    repeat (2) @(negedge clock);
    check("rst_ocupado", {31'b0, ocupado}, 0);
    check("rst_addr", {28'b0, mem_addr}, 0);
    check("rst_valida", {31'b0, linha_valida}, 0);
    check("rst_idx", {28'b0, linha_idx}, 0);
    check("rst_dados", {16'b0, linha_dados}, 0);
    check("rst_contagem", {27'b0, contagem_aste}, 0);
    check("rst_sob", {31'b0, sobreposicao}, 0);
    check("rst_fim", {31'b0, fim_quadro}, 0);
    reset_n = 1'b1;

    // Empty frame
    clear_all();
    run_frame(-1, 0, 1'b0, fc);
    verifica("vazio", fc, 34, 0, 1'b0);

    // Single live asteroid plus ship
    clear_all();
    set_entry(3, 5, 2, 2'b10);
    mostra_nave = 1'b1; nave_coor_x = 4'd7; nave_coor_y = 4'd7;
    exp_rows[2] = 16'h0020; exp_rows[7] = 16'h0080;
    run_frame(-1, 0, 1'b0, fc);
    verifica("unico", fc, 34, 1, 1'b0);

    // Destroyed entry filtered
    clear_all();
    set_entry(0, 0, 0, 2'b11);
    mostra_nave = 1'b0;
    run_frame(-1, 0, 1'b0, fc);
    verifica("destruido", fc, 34, 0, 1'b0);

    // Two live asteroids in one cell
    clear_all();
    set_entry(1, 3, 4, 2'b10);
    set_entry(9, 3, 4, 2'b10);
    mostra_nave = 1'b1; nave_coor_x = 4'd0; nave_coor_y = 4'd0;
    exp_rows[0] = 16'h0001; exp_rows[4] = 16'h0008;
    run_frame(-1, 0, 1'b0, fc);
    verifica("sobrepos", fc, 34, 2, 1'b1);

    // Backpressure at row 6, ship on asteroid, corner cell from the last slot
    clear_all();
    set_entry(3, 5, 2, 2'b10);
    set_entry(7, 10, 6, 2'b10);
    set_entry(15, 15, 15, 2'b10);
    mostra_nave = 1'b1; nave_coor_x = 4'd5; nave_coor_y = 4'd2;
    exp_rows[2] = 16'h0020; exp_rows[6] = 16'h0400; exp_rows[15] = 16'h8000;
    run_frame(6, 5, 1'b1, fc);
    verifica("contrapressao", fc, 39, 3, 1'b1);

    // Reset during LEITURA k=8
    clear_all();
    set_entry(1, 3, 4, 2'b10);
    set_entry(9, 3, 4, 2'b10);
    mostra_nave = 1'b1; nave_coor_x = 4'd0; nave_coor_y = 4'd0;
    exp_rows[0] = 16'h0001; exp_rows[4] = 16'h0008;
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    repeat (9) @(negedge clock);
    check("pre_rst_addr", {28'b0, mem_addr}, 9);
    check("pre_rst_contagem", {27'b0, contagem_aste}, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ocupado", {31'b0, ocupado}, 0);
    check("mid_rst_addr", {28'b0, mem_addr}, 0);
    check("mid_rst_contagem", {27'b0, contagem_aste}, 0);
    check("mid_rst_sob", {31'b0, sobreposicao}, 0);
    check("mid_rst_valida", {31'b0, linha_valida}, 0);
    check("mid_rst_dados", {16'b0, linha_dados}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mid_rst_sem_fim", {31'b0, fim_quadro}, 0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("pos_rst_ocioso", {31'b0, ocupado}, 0);
    end
    run_frame(-1, 0, 1'b0, fc);
    verifica("pos_reset", fc, 34, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/leitor_quadro_aste.md
Name: leitor_quadro_aste

Overview:
- Read-side counterpart to the asteroid datapath.
- On each frame tick it sweeps the 16-entry asteroid position memory and its load/destroyed memory through their read ports, and rasterises live asteroids plus the ship into a 16x16 occupancy bitmap.
- It then streams the bitmap row by row to the display driver over a valid/ready handshake.
- It sits between the asteroid/ship datapaths and the LED-matrix/display module.

Parameters:
- N_ASTE, 16, number of asteroid slots swept per frame; must equal 2**LARG_END.
- LARG_END, 4, width of the memory address.
- LARG_COOR, 4, width of one coordinate; the bitmap is 2**LARG_COOR square.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iniciar  in  1  frame-start pulse; sampled only in OCIOSO.
- mem_addr  out  LARG_END  read address shared by the position memory and the load memory.
- mem_dado  in  10  position entry: {x[9:6], y[5:2], opcode[1:0]}; valid one cycle after mem_addr.
- mem_load  in  2  {loaded, destruido}; valid one cycle after mem_addr.
- mostra_nave  in  1  when 1, draw the ship cell.
- nave_coor_x  in  LARG_COOR  ship column.
- nave_coor_y  in  LARG_COOR  ship row.
- linha_valida  out  1  row beat valid.
- linha_pronta  in  1  display accepts the beat.
- linha_idx  out  LARG_COOR  row number of the current beat.
- linha_dados  out  2**LARG_COOR  row bits; bit x = column x.
- ocupado  out  1  high in every state except OCIOSO.
- fim_quadro  out  1  one-cycle pulse after the last row is accepted.
- contagem_aste  out  LARG_END+1  number of live asteroids in the frame; range 0..16.
- sobreposicao  out  1  set when a live asteroid lands on an already-set cell.

Behaviour:
- Reset, asynchronous:
  - State = OCIOSO.
  - Bitmap, mem_addr, linha_idx, linha_dados, contagem_aste, sobreposicao, linha_valida, fim_quadro all = 0.
  - Reset mid-frame aborts the frame immediately; no fim_quadro is produced.
- OCIOSO:
  - iniciar=1 -> LIMPA. iniciar=0 -> stay.
- LIMPA, 1 cycle:
  - Clear bitmap, contagem_aste and sobreposicao.
  - If mostra_nave=1, set bitmap[nave_coor_y][nave_coor_x].
  - Drive mem_addr=0.
  - Next state LEITURA with k=0.
- LEITURA, exactly N_ASTE cycles, k = 0..N_ASTE-1:
  - mem_dado and mem_load belong to address k. mem_addr is driven to k+1; on the last cycle it wraps to 0 and the value is ignored.
  - An entry is live iff loaded=1 and destruido=0. For a live entry:
    - If bitmap[y][x] is already set, set sobreposicao (sticky until next LIMPA).
    - Set bitmap[y][x].
    - Increment contagem_aste.
  - Non-live entries are ignored. Opcode is ignored.
  - Ship and asteroid in the same cell count as overlap.
  - Two live asteroids in one cell: the bit stays 1, the count is 2, sobreposicao=1.
  - After k=N_ASTE-1 -> ENVIA with r=0.
- ENVIA:
  - linha_valida=1, linha_idx=r, linha_dados=bitmap[r].
  - Outputs hold stable while linha_pronta=0.
  - When linha_pronta=1 (beat accepted): if r<15, r++ and the next row is presented the following cycle; if r=15 -> FIM.
  - Back-to-back acceptance gives 1 row per cycle.
- FIM, 1 cycle:
  - fim_quadro=1, linha_valida=0, then -> OCIOSO.
  - contagem_aste and sobreposicao hold their values until the next LIMPA.
- iniciar is ignored while ocupado=1; no queuing.
- Bitmap contents are frozen from the end of LEITURA through ENVIA. Memory writes during ENVIA do not affect the current frame.
- Minimum frame length: 1 (LIMPA) + N_ASTE + 16 + 1 cycles = 34 at defaults, with linha_pronta tied high.

Decomposition:
- Shared package aste_pkg holds:
  - Field constants POS_X_MSB=9, POS_X_LSB=6, POS_Y_MSB=5, POS_Y_LSB=2, OPCODE_MSB=1.
  - BIT_LOADED=1, BIT_DESTRUIDO=0.
  - State encoding: OCIOSO, LIMPA, LEITURA, ENVIA, FIM.
- Sub-module quadro_bitmap: 16x16 flop array with clear, single-cell set, ship-set and row-read ports. It also returns the pre-set value of the addressed cell for overlap detection.

Test Plan:
- Empty frame. All entries loaded=0, mostra_nave=0, linha_pronta=1, pulse iniciar. Required: 16 rows with linha_dados=0, linha_idx 0..15; fim_quadro at cycle 34 after iniciar; contagem_aste=0; sobreposicao=0.
- Single live asteroid plus ship. Entry 3 = {x=5, y=2}, loaded=1, destruido=0; ship at (7,7); mostra_nave=1. Required: row2=16'h0020, row7=16'h0080, all other rows 0; contagem_aste=1.
- Destroyed entry filtered. Entry 0 = {x=0, y=0}, loaded=1, destruido=1. Required: row0=0; contagem_aste=0.
- Overlap. Entries 1 and 9 both at (3,4) and live; ship at (0,0). Required: row4=16'h0008; contagem_aste=2; sobreposicao=1.
- Backpressure. linha_pronta low for 5 cycles at row 6. Required: linha_idx=6 and linha_dados stable throughout; no row skipped; fim_quadro delayed by exactly 5 cycles; iniciar pulses during ENVIA are ignored.
- Reset mid-frame. Assert reset_n=0 during LEITURA k=8. Required: all outputs 0 immediately; state OCIOSO; no fim_quadro; the next iniciar produces a clean, complete frame.
